// File: rtl/sopc_anemo_pio_pkg.sv
// Shared register map for the anemometer SOPC parallel I/O ports.
// Used by both the input PIO and the output PIO.
package sopc_anemo_pio_pkg;

    typedef logic [1:0] reg_addr_t;

    localparam reg_addr_t ADDR_DATA     = 2'd0;
    localparam reg_addr_t ADDR_EDGE_SEL = 2'd1;
    localparam reg_addr_t ADDR_IRQ_MASK = 2'd2;
    localparam reg_addr_t ADDR_EDGE_CAP = 2'd3;

    // Cycles after reset release before edges are trusted.
    localparam logic [1:0] ARM_CYCLES = 2'd3;

endpackage

// File: rtl/sopc_anemo_edge_detect.sv
// One input bit: 3-flop synchronizer plus polarity-selected edge pulse.
// Latency: sync output 2 edges after sampling; pulse valid between edges 2 and 3.
// No backpressure: free-running sampler.
module sopc_anemo_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    input  logic edge_sel,
    input  logic armed,
    output logic sync,
    output logic edge_pulse
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= in_bit;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sync = s2;

    // edge_sel = 1 selects the falling edge, 0 the rising edge
    assign edge_pulse = armed & (edge_sel ? (s3 & ~s2) : (~s3 & s2));

endmodule

// File: rtl/sopc_anemo_entree_pio.sv
// Avalon-MM input PIO with per-bit sticky edge capture and level interrupt.
// Latency: zero-wait-state combinational reads; writes take effect at the write edge.
// No backpressure: slave never stalls, edges captured every cycle.
module sopc_anemo_entree_pio
    import sopc_anemo_pio_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic             wr;
    logic [1:0]       arm_cnt;
    logic             armed;
    logic [WIDTH-1:0] sync_bits;
    logic [WIDTH-1:0] edge_pulses;
    logic [WIDTH-1:0] edge_sel;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] cap_clr;
    logic             unused_writedata;

    assign wr               = chipselect & ~write_n;
    assign unused_writedata = ^writedata;

    // Holds off capture until the synchronizer has flushed post-reset levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt <= 2'd0;
        end else if (arm_cnt != ARM_CYCLES) begin
            arm_cnt <= arm_cnt + 2'd1;
        end
    end

    assign armed = (arm_cnt == ARM_CYCLES);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sopc_anemo_edge_detect u_edge (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_bit    (in_port[i]),
            .edge_sel  (edge_sel[i]),
            .armed     (armed),
            .sync      (sync_bits[i]),
            .edge_pulse(edge_pulses[i])
        );
    end

    assign cap_clr = (wr && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_sel <= '0;
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            if (wr && address == ADDR_EDGE_SEL) edge_sel <= writedata[WIDTH-1:0];
            if (wr && address == ADDR_IRQ_MASK) irq_mask <= writedata[WIDTH-1:0];
            // A new edge in the same cycle as its clear keeps the bit set.
            edge_cap <= (edge_cap & ~cap_clr) | edge_pulses;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0] = sync_bits;
            ADDR_EDGE_SEL: readdata[WIDTH-1:0] = edge_sel;
            ADDR_IRQ_MASK: readdata[WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAP: readdata[WIDTH-1:0] = edge_cap;
        endcase
    end

    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_sopc_anemo_entree_pio.sv
// Bench for the input PIO: directed vector table, reset corner cases, random run vs history model.
module tb_sopc_anemo_entree_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int total = 0;
    int bad   = 0;

    sopc_anemo_entree_pio #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Reference model: every in_port value seen at an edge since reset, plus the three registers.
    logic [7:0] samp[$];
    int         n_edges;
    logic [7:0] m_sel, m_mask, m_cap;

    function automatic logic [7:0] sample_at(input int k);
        if (k < 1) return 8'h00;
        return samp[k-1];
    endfunction

    function automatic logic [31:0] m_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {24'h0, sample_at(n_edges - 1)};
            2'd1:    return {24'h0, m_sel};
            2'd2:    return {24'h0, m_mask};
            default: return {24'h0, m_cap};
        endcase
    endfunction

    function automatic logic m_irq();
        return |(m_cap & m_mask);
    endfunction

    task automatic model_reset();
        samp.delete();
        n_edges = 0;
        m_sel   = 8'h00;
        m_mask  = 8'h00;
        m_cap   = 8'h00;
    endtask

    task automatic model_edge();
        logic [7:0] cur, prev, det, clr;
        logic       w;
        if (!reset_n) return;
        n_edges++;
        samp.push_back(in_port);
        det = 8'h00;
        // Edges are only trusted once three clocks have passed since reset release.
        if (n_edges >= 4) begin
            cur  = sample_at(n_edges - 2);
            prev = sample_at(n_edges - 3);
            for (int b = 0; b < 8; b++)
                det[b] = m_sel[b] ? (prev[b] && !cur[b]) : (!prev[b] && cur[b]);
        end
        w   = chipselect && !write_n;
        clr = (w && address == 2'd3) ? writedata[7:0] : 8'h00;
        m_cap = (m_cap & ~clr) | det;
        if (w && address == 2'd1) m_sel  = writedata[7:0];
        if (w && address == 2'd2) m_mask = writedata[7:0];
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic [1:0] a, input logic cs, input logic wn,
                        input logic [31:0] wd, input logic [7:0] ip);
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        in_port    = ip;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [7:0]  ip;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic rdv(input logic [1:0] a, input logic [7:0] ip, input logic [31:0] er, input logic ei);
        vec_t v;
        v.addr = a; v.cs = 1'b1; v.wn = 1'b1; v.wd = 32'h0; v.ip = ip;
        v.exp_rd = er; v.exp_irq = ei;
        vecs.push_back(v);
    endtask

    task automatic wrv(input logic [1:0] a, input logic [31:0] wd, input logic [7:0] ip,
                       input logic [31:0] er, input logic ei);
        vec_t v;
        v.addr = a; v.cs = 1'b1; v.wn = 1'b0; v.wd = wd; v.ip = ip;
        v.exp_rd = er; v.exp_irq = ei;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] rip;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'hFF;
        model_reset();

        // Expected register view after each clock edge (post-edge values).
        rdv(0, 8'h00, 32'hFF, 0);
        rdv(0, 8'h00, 32'h00, 0);
        rdv(3, 8'h00, 32'h00, 0);
        wrv(2, 32'h01, 8'h00, 32'h01, 0);
        rdv(3, 8'h01, 32'h00, 0);
        rdv(3, 8'h01, 32'h00, 0);
        rdv(3, 8'h01, 32'h01, 1);
        wrv(3, 32'h01, 8'h01, 32'h00, 0);
        wrv(1, 32'hFFFF_FF80, 8'h01, 32'h80, 0);
        wrv(2, 32'h80, 8'h01, 32'h80, 0);
        rdv(3, 8'h81, 32'h00, 0);
        rdv(3, 8'h81, 32'h00, 0);
        rdv(3, 8'h81, 32'h00, 0);
        rdv(3, 8'h01, 32'h00, 0);
        rdv(3, 8'h01, 32'h00, 0);
        rdv(3, 8'h01, 32'h80, 1);
        wrv(3, 32'h80, 8'h01, 32'h00, 0);
        wrv(2, 32'h08, 8'h01, 32'h08, 0);
        rdv(3, 8'h09, 32'h00, 0);
        rdv(3, 8'h09, 32'h00, 0);
        wrv(3, 32'h08, 8'h09, 32'h08, 1);
        rdv(3, 8'h09, 32'h08, 1);
        wrv(3, 32'h08, 8'h09, 32'h00, 0);
        wrv(2, 32'h00, 8'h09, 32'h00, 0);
        rdv(3, 8'h29, 32'h00, 0);
        rdv(3, 8'h29, 32'h00, 0);
        rdv(3, 8'h29, 32'h20, 0);
        wrv(2, 32'h20, 8'h29, 32'h20, 1);
        rdv(3, 8'h29, 32'h20, 1);
        wrv(1, 32'h00, 8'h29, 32'h00, 1);
        wrv(2, 32'hFF, 8'h29, 32'hFF, 1);
        rdv(3, 8'h00, 32'h20, 1);
        rdv(3, 8'h00, 32'h20, 1);
        rdv(3, 8'h00, 32'h20, 1);
        rdv(3, 8'hFF, 32'h20, 1);
        rdv(3, 8'hFF, 32'h20, 1);
        rdv(3, 8'hFF, 32'hFF, 1);

        // Reset release with all inputs high: no false captures, DATA follows after 2 edges.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step(2'd3, 1'b0, 1'b1, 32'h0, 8'hFF);
            chk("rel_cap", readdata, 32'h0);
            chk("rel_irq", {31'h0, irq}, 32'h0);
            address = 2'd0;
            #1;
            chk("rel_data", readdata, (i >= 2) ? 32'hFF : 32'h0);
        end

        foreach (vecs[i]) begin
            step(vecs[i].addr, vecs[i].cs, vecs[i].wn, vecs[i].wd, vecs[i].ip);
            chk($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
            chk($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
        end

        // Asynchronous reset while EDGE_CAP=0xFF and irq is high.
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_irq", {31'h0, irq}, 32'h0);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            chk($sformatf("arst_rd%0d", a), readdata, 32'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step(2'd0, 1'b1, 1'b0, 32'h55, 8'hFF);
        chk("datawr", readdata, m_rd(2'd0));
        for (int a = 1; a < 4; a++) begin
            step(2'(a), 1'b1, 1'b1, 32'h0, 8'hFF);
            chk($sformatf("post_rd%0d", a), readdata, 32'h0);
        end
        step(2'd0, 1'b1, 1'b1, 32'h0, 8'hFF);
        chk("post_data", readdata, 32'hFF);
        chk("post_irq", {31'h0, irq}, 32'h0);

        // Random traffic checked against the history model, with one reset in the middle.
        rip = 8'hFF;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                reset_n = 1'b0;
                model_reset();
            end
            if (i == 202) reset_n = 1'b1;
            if ($urandom_range(0, 1) == 0) rip = 8'($urandom);
            step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) != 0), $urandom, rip);
            chk("rand_rd", readdata, m_rd(address));
            chk("rand_irq", {31'h0, irq}, {31'h0, m_irq()});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
